// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : PC owner and word-aligned imem requester with a credit-limited
//            in-order instruction buffer and branch-redirect squashing.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 2;

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_resp_pc;
  logic [c_CW-1:0] r_outstanding;
  logic [c_CW-1:0] r_drop_cnt;
  logic [c_AW:0]   r_wr_ptr;
  logic [c_AW:0]   r_rd_ptr;
  logic [31:0]     r_fifo_instr [FIFO_DEPTH];
  logic [31:0]     r_fifo_pc    [FIFO_DEPTH];

  logic [c_AW:0]   w_count;
  logic [c_CW-1:0] w_credit;
  logic [c_CW-1:0] w_out_next;
  logic            w_fire;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_credit   = r_outstanding - r_drop_cnt + c_CW'(w_count);
  assign w_fire     = imem_req_valid && imem_req_ready;
  assign w_resp     = imem_resp_valid && (r_outstanding != '0);
  assign w_push     = w_resp && (r_drop_cnt == '0) && !redirect_valid;
  assign w_pop      = instr_valid && instr_ready;
  assign w_out_next = r_outstanding + c_CW'(w_fire) - c_CW'(w_resp);

  assign imem_req_valid = !reset && !redirect_valid && (w_credit < c_CW'(FIFO_DEPTH));
  assign imem_req_addr  = r_fetch_pc;

  assign instr_valid = (w_count != '0);
  assign instruction = instr_valid ? r_fifo_instr[r_rd_ptr[c_AW-1:0]] : 32'h0;
  assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr[c_AW-1:0]]    : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the wrong path.
      r_fetch_pc    <= {redirect_target[31:2], 2'b00};
      r_resp_pc     <= {redirect_target[31:2], 2'b00};
      r_outstanding <= w_out_next;
      r_drop_cnt    <= w_out_next;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_resp && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - c_CW'(1);
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Correct-path responses arrive in order, so a running PC tags each word.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_fifo_instr[r_wr_ptr[c_AW-1:0]] <= imem_resp_data;
      r_fifo_pc[r_wr_ptr[c_AW-1:0]]    <= r_resp_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Directed and randomized bench for instruction_fetch against a
//            queue-based reference model and an in-order memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
  localparam int          c_DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  instruction_fetch #(.RESET_PC(c_RESET_PC), .FIFO_DEPTH(c_DEPTH)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .instr_pc        (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit stale; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  infl_t       m_infl[$];
  ent_t        m_fifo[$];
  logic [31:0] mem_q[$];
  logic [31:0] m_pc;
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit rst, input bit rdv, input logic [31:0] tgt,
                      input bit resp_en, input bit mrdy, input bit drdy);
    bit          do_resp;
    bit          exp_rv;
    logic [31:0] rdata;
    int          live;
    infl_t       e;
    @(negedge clk);
    do_resp = !rst && resp_en && (mem_q.size() > 0);
    rdata   = do_resp ? memdata(mem_q[0]) : $urandom;
    reset           = rst;
    redirect_valid  = rdv;
    redirect_target = tgt;
    imem_resp_valid = do_resp;
    imem_resp_data  = rdata;
    imem_req_ready  = mrdy;
    instr_ready     = drdy;
    #1;
    live = 0;
    foreach (m_infl[i]) if (!m_infl[i].stale) live++;
    exp_rv = !rst && !rdv && ((live + m_fifo.size()) < c_DEPTH);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_fifo.size() != 0});
    chk("instruction", instruction, (m_fifo.size() != 0) ? m_fifo[0].ins : 32'h0);
    chk("instr_pc", instr_pc, (m_fifo.size() != 0) ? m_fifo[0].pc : 32'h0);
    if (rst) begin
      m_infl.delete();
      m_fifo.delete();
      mem_q.delete();
      m_pc = c_RESET_PC;
    end else begin
      if ((m_fifo.size() != 0) && drdy) void'(m_fifo.pop_front());
      if (do_resp) begin
        void'(mem_q.pop_front());
        e = m_infl.pop_front();
        if (!e.stale && !rdv) m_fifo.push_back('{pc: e.pc, ins: rdata});
      end
      if (rdv) begin
        m_fifo.delete();
        foreach (m_infl[i]) m_infl[i].stale = 1'b1;
        m_pc = {tgt[31:2], 2'b00};
      end else if (exp_rv && mrdy) begin
        m_infl.push_back('{pc: m_pc, stale: 1'b0});
        mem_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    imem_req_ready = 1'b0; instr_ready = 1'b0;
    m_pc = c_RESET_PC;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 1, 1, 1);
    chk("reset_req_valid", {31'b0, imem_req_valid}, 32'h0);

    // Sequential fetch with a 1-cycle memory and always-ready decode.
    repeat (20) step(0, 0, 0, 1, 1, 1);
    // Decode stall holds the head; fetch throttles on credit.
    repeat (5) step(0, 0, 0, 1, 1, 0);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
    repeat (8) step(0, 0, 0, 1, 1, 1);

    // Two requests in flight, then redirect; their responses must be dropped.
    repeat (2) step(0, 0, 0, 0, 1, 1);
    step(0, 1, 32'h0000_0100, 0, 1, 1);
    chk("redirect_no_req", {31'b0, imem_req_valid}, 32'h0);
    repeat (8) step(0, 0, 0, 1, 1, 1);

    // Redirect coinciding with a response and a pop.
    step(0, 1, 32'h0000_0400, 1, 1, 1);
    chk("flush_no_req", {31'b0, imem_req_valid}, 32'h0);
    repeat (6) step(0, 0, 0, 1, 1, 1);

    // Misaligned target and PC wrap.
    step(0, 1, 32'h0000_0203, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    chk("misaligned_addr", imem_req_addr, 32'h0000_0200);
    step(0, 1, 32'hFFFF_FFFC, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    chk("wrap_first", imem_req_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 1, 1);
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);
    repeat (6) step(0, 0, 0, 1, 1, 1);

    // Mid-operation reset with a full buffer.
    repeat (6) step(0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1);
    chk("post_reset_valid", {31'b0, instr_valid}, 32'h0);
    chk("post_reset_addr", imem_req_addr, c_RESET_PC);
    repeat (6) step(0, 0, 0, 1, 1, 1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 150) == 0, ($urandom % 10) == 0, $urandom,
           ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
